// File: rtl/serial_alu_sequencer.sv
// Bit-serial add/sub/inc/dec sequencer driving a single 1-bit full-adder slice.
// Operands stream LSB first; the sum shifts into result from the MSB end.
module serial_alu_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             capture;
   logic             last;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] b_eff;
   logic             c_init;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sum_bit;
   logic             c_next;

   assign last = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               capture   = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // A start in the done cycle chains straight into the next run
            if (start) begin
               capture   = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      b_eff  = '0;
      c_init = 1'b0;
      unique case (op)
         2'b00: begin
            b_eff  = b_in;
            c_init = 1'b0;
         end
         2'b01: begin
            b_eff  = ~b_in;
            c_init = 1'b1;
         end
         2'b10: begin
            b_eff  = '0;
            c_init = 1'b1;
         end
         2'b11: begin
            b_eff  = '1;
            c_init = 1'b0;
         end
      endcase
   end

   assign sum_bit = a_sr[0] ^ b_sr[0] ^ carry;
   assign c_next  = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr      <= '0;
         b_sr      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (capture) begin
         a_sr  <= a_in;
         b_sr  <= b_eff;
         carry <= c_init;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         result <= {sum_bit, result[WIDTH-1:1]};
         carry  <= c_next;
         cnt    <= cnt + 1'b1;
         // On the MSB slice, carry still holds the carry into the MSB
         if (last) begin
            carry_out <= c_next;
            overflow  <= carry ^ c_next;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer at WIDTH=8.
// Expected values are hand-computed per vector.
module tb_serial_alu_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       carry_out;
   logic       overflow;

   int n_checks;
   int n_fail;

   serial_alu_sequencer #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a_in      (a_in),
      .b_in      (b_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b);
      start = 1'b1;
      op    = o;
      a_in  = a;
      b_in  = b;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input bit noise, output int lat,
                            output int nbusy);
      lat   = 0;
      nbusy = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (noise) begin
            if (k == 3 || k == 5) begin
               start = 1'b1;
               op    = 2'b00;
               a_in  = 8'hFF;
               b_in  = 8'h11;
            end else begin
               start = 1'b0;
            end
         end
         if (busy) nbusy++;
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [1:0] o,
                        input logic [7:0] a, input logic [7:0] b,
                        input bit noise, input logic [7:0] er,
                        input logic ec, input logic ev);
      int lat;
      int nb;
      @(negedge clk);
      launch(o, a, b);
      wait_done(noise, lat, nb);
      check({tag, "_lat"}, 32'(lat), 32'd9);
      check({tag, "_busy"}, 32'(nb), 32'd8);
      check({tag, "_res"}, 32'(result), 32'(er));
      check({tag, "_c"}, 32'(carry_out), 32'(ec));
      check({tag, "_v"}, 32'(overflow), 32'(ev));
   endtask

   initial begin
      int lat;
      int nb;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      start    = 1'b0;
      op       = 2'b00;
      a_in     = 8'h00;
      b_in     = 8'h00;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", 32'(result), 32'd0);
      check("rst_c", 32'(carry_out), 32'd0);
      check("rst_v", 32'(overflow), 32'd0);
      rst = 1'b0;

      do_op("add", 2'b00, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
      do_op("sub_lo", 2'b01, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
      do_op("sub_hi", 2'b01, 8'h20, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0);
      do_op("inc", 2'b10, 8'hFF, 8'hAA, 1'b0, 8'h00, 1'b1, 1'b0);
      do_op("ign", 2'b00, 8'h12, 8'h34, 1'b1, 8'h46, 1'b0, 1'b0);

      // Back-to-back: second start presented in the done cycle
      do_op("b2b_a", 2'b00, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      check("b2b_done", 32'(done), 32'd1);
      launch(2'b00, 8'h01, 8'h01);
      wait_done(1'b0, lat, nb);
      check("b2b_lat", 32'(lat), 32'd9);
      check("b2b_busy", 32'(nb), 32'd8);
      check("b2b_res", 32'(result), 32'h02);
      check("b2b_c", 32'(carry_out), 32'd0);
      check("b2b_v", 32'(overflow), 32'd0);
      @(negedge clk);
      check("b2b_done_end", 32'(done), 32'd0);
      check("b2b_idle", 32'(busy), 32'd0);

      do_op("dec", 2'b11, 8'h80, 8'h00, 1'b0, 8'h7F, 1'b1, 1'b1);

      // Abort in the middle of a run with an asynchronous reset
      @(negedge clk);
      launch(2'b00, 8'h5A, 8'h3C);
      repeat (4) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_res", 32'(result), 32'd0);
      check("arst_c", 32'(carry_out), 32'd0);
      check("arst_v", 32'(overflow), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("arst_done", 32'(done), 32'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_done", 32'(done), 32'd0);
      end

      do_op("post", 2'b01, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
